seven_segment_scan: RTL and testbench
=====================================

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameters SHALL be: DIGITS, default 2, number of multiplexed digits, legal 1..8.
REQ-002 Parameter REFRESH_DIV, default 12000, SHALL set the clk cycles each digit is lit (1 kHz/digit at 12 MHz), legal >=2.
REQ-003 Parameter GAP_CYCLES, default 8, SHALL set the anti-ghosting dead time between digits with all digits off; 0 means no gap.
REQ-004 Parameter ACTIVE_LOW, default 1, SHALL invert seg, dp and dig_en when 1 (lit = 0).
REQ-005 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 load_valid  in  1  new display value offered.
REQ-008 load_ready  out  1  value will be accepted this cycle.
REQ-009 load_value  in  4*DIGITS  one nibble per digit; nibble 0 drives digit 0 (least significant).
REQ-010 load_dp  in  DIGITS  decimal point per digit.
REQ-011 hex_mode  in  1  1 = hex glyphs, 0 = decimal/BCD glyphs.
REQ-012 blank  in  1  forces all digits off.
REQ-013 seg  out  7  segments, bit order GFEDCBA.
REQ-014 dp  out  1  decimal point of the active digit.
REQ-015 dig_en  out  DIGITS  one-hot digit enable.

Function
REQ-016 All outputs SHALL be registered: one cycle from internal state to pins.
REQ-017 The FSM SHALL have states GAP and SHOW: GAP lasts GAP_CYCLES cycles with all digits off, then SHOW lasts REFRESH_DIV cycles with digit idx lit, then idx advances and the FSM returns to GAP. When GAP_CYCLES=0, the FSM SHALL go SHOW to SHOW directly.
REQ-018 idx SHALL count 0..DIGITS-1 and wrap to 0; the wrap marks a frame boundary.
REQ-019 Handshake: a transfer SHALL occur when load_valid && load_ready; load_value and load_dp go to a pending register, and load_ready SHALL go low the next cycle.
REQ-020 Pending data SHALL commit to the display register on the cycle the FSM enters SHOW with idx=0; load_ready SHALL return high the following cycle.
REQ-021 Latency from capture to visible SHALL be at most one frame plus one cycle; the display SHALL never mix digits from two values (no tearing).
REQ-022 A load accepted on the same cycle as a commit opportunity SHALL NOT commit that cycle; it commits at the next frame boundary.
REQ-023 Glyphs (GFEDCBA, active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-024 With hex_mode=0, nibbles 10..15 SHALL display '-' (1000000).
REQ-025 hex_mode SHALL be sampled live, not latched with the value.
REQ-026 While blank=1, dig_en SHALL be all-inactive; the FSM and counters SHALL keep running, so release resumes at the current idx.

Reset
REQ-027 On rst, the block SHALL set state=GAP, idx=0, counter=0, display register=0, and drop pending data.
REQ-028 Reset output values SHALL be: seg, dp and dig_en all inactive; load_ready=1.
REQ-029 rst asserted mid-frame or with pending data SHALL take effect next edge; pending data is lost.

Configuration
REQ-030 The macro is SEG_LEADING_ZERO_BLANK_EN.
REQ-031 With SEG_LEADING_ZERO_BLANK_EN defined and hex_mode=0, zero digits above the most significant non-zero digit SHALL show no segments; digit 0 is always shown and dp is kept.
REQ-032 Without the macro, all digits SHALL always be shown.

Structure
REQ-033 A shared package seven_segment_pkg SHALL hold the glyph constant table, the dash glyph, and the FSM state enum.
REQ-034 Sub-module seg_glyph_decoder (combinational: nibble, hex_mode -> 7-bit glyph) SHALL be instantiated once.

Verification (DIGITS=2, REFRESH_DIV=4, GAP_CYCLES=1, ACTIVE_LOW=1)
REQ-035 Reset: rst high 2 cycles -> seg=7'h7F, dp=1, dig_en=2'b11, load_ready=1; first lit digit 2 cycles after rst release.
REQ-036 Hex load: load 8'h42, hex_mode=1 -> after frame boundary, dig_en=2'b10 with seg=7'h24 for 4 cycles, 1 gap cycle, then dig_en=2'b01 with seg=7'h19, repeating with period 10.
REQ-037 Mode: load 8'h0C -> digit 0 seg=7'h3F with hex_mode=0; seg=7'h46 after switching hex_mode=1 mid-frame.
REQ-038 Back-to-back: offer 8'h11 then 8'h22 continuously -> load_ready low between; 11 displayed a full frame, then 22; no mixed frame.
REQ-039 Blank/reset: blank pulse mid-SHOW -> dig_en=2'b11 next cycle, scan position preserved; rst with pending data -> display 00, load_ready=1.
REQ-040 Macro: decimal 8'h05 -> with SEG_LEADING_ZERO_BLANK_EN, digit 1 seg=7'h7F; without it, digit 1 seg=7'h40.

Source files
------------

// File: rtl/seven_segment_scan_pkg.sv
// seven_segment_pkg: definitions shared by the seven-segment scanner.
//   - scan_state_e : scan FSM states (GAP = all digits dark, SHOW = one digit lit)
//   - GLYPH_TABLE  : active-high GFEDCBA glyphs for nibbles 0..F
//   - DASH_GLYPH   : glyph used for nibbles 10..15 in decimal mode
package seven_segment_pkg;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  localparam logic [6:0] DASH_GLYPH = 7'b1000000;

  // Entry n is the glyph for nibble n; the concatenation runs from F down to 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/seven_segment_scan_if.sv
// seven_segment_scan_if: valid/ready load channel for the display value.
//   load_valid  master->slave  new display value offered
//   load_ready  slave->master  value is accepted on this cycle if valid
//   load_value  master->slave  4*DIGITS bits, nibble 0 = digit 0
//   load_dp     master->slave  decimal point per digit
interface seven_segment_scan_if #(
  parameter int DIGITS = 2
) ();
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_value;
  logic [DIGITS-1:0]     load_dp;

  modport master (output load_valid, output load_value, output load_dp, input  load_ready);
  modport slave  (input  load_valid, input  load_value, input  load_dp, output load_ready);
endinterface

// File: rtl/seg_glyph_decoder.sv
// seg_glyph_decoder: combinational nibble -> GFEDCBA glyph (active-high).
//   nibble_i   : value to display
//   hex_mode_i : 1 = hex glyphs, 0 = decimal (10..15 shown as a dash)
//   glyph_o    : segment pattern, bit 6 = G ... bit 0 = A
module seg_glyph_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] glyph_o
);
  always_comb begin
    glyph_o = GLYPH_TABLE[nibble_i];
    if (!hex_mode_i && (nibble_i > 4'd9)) glyph_o = DASH_GLYPH;
  end
endmodule

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed seven-segment display driver.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load_if   : valid/ready channel (slave) carrying value + decimal points
//   hex_mode  : live glyph mode, 1 = hex, 0 = decimal
//   blank     : forces every digit off while the scan keeps running
//   seg, dp   : registered segments (GFEDCBA) and decimal point of active digit
//   dig_en    : registered one-hot digit enable
// Build option: define SEG_LEADING_ZERO_BLANK_EN to darken leading zero digits
// in decimal mode (digit 0 always shown, decimal points kept).
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 12000,
  parameter int GAP_CYCLES  = 8,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_segment_scan_if.slave     load_if,
  input  logic                    hex_mode,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [DIGITS-1:0]       dig_en
);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic             OUT_INV   = (ACTIVE_LOW != 0);

  scan_state_e             state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DIGITS-1:0][3:0]  disp_val_q, pend_val_q;
  logic [DIGITS-1:0]       disp_dp_q, pend_dp_q;
  logic                    ready_q;  // low exactly while pending data waits
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [DIGITS-1:0]       dig_en_q;

  logic [IDX_W-1:0]        idx_nxt;
  logic                    gap_done, show_done, frame_start, commit, transfer;
  logic [6:0]              glyph;
  logic                    lead_zero;
  logic [DIGITS-1:0]       onehot;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [DIGITS-1:0]       dig_en_d;

  assign idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  assign gap_done  = (GAP_CYCLES == 0) || (cnt_q == GAP_LAST);
  assign show_done = (cnt_q == SHOW_LAST);

  // A frame starts on the edge that moves the FSM into SHOW with idx 0.
  always_comb begin
    frame_start = 1'b0;
    if (state_q == ST_GAP)     frame_start = gap_done && (idx_q == '0);
    else if (GAP_CYCLES == 0)  frame_start = show_done && (idx_nxt == '0);
  end

  // Commit needs ready low, transfer needs ready high, so they never collide;
  // a value captured on a frame start therefore waits for the next frame.
  assign commit   = frame_start && !ready_q;
  assign transfer = load_if.load_valid && ready_q;
  assign load_if.load_ready = ready_q;

  seg_glyph_decoder u_glyph (
    .nibble_i   (disp_val_q[idx_q]),
    .hex_mode_i (hex_mode),
    .glyph_o    (glyph)
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
    assign onehot[gi] = (idx_q == IDX_W'(gi));
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // zero_above[i]: digits i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] zero_above;
  always_comb begin
    zero_above = '0;
    zero_above[DIGITS-1] = (disp_val_q[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      zero_above[i] = (disp_val_q[i] == 4'd0) && zero_above[i+1];
  end
  assign lead_zero = !hex_mode && (idx_q != '0) && zero_above[idx_q];
`else
  assign lead_zero = 1'b0;
`endif

  // Active-high view of the pins; polarity is applied at the register.
  always_comb begin
    seg_d    = '0;
    dp_d     = 1'b0;
    dig_en_d = '0;
    if ((state_q == ST_SHOW) && !blank) begin
      dig_en_d = onehot;
      dp_d     = disp_dp_q[idx_q];
      if (!lead_zero) seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GAP;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      ready_q    <= 1'b1;
      seg_q      <= {7{OUT_INV}};
      dp_q       <= OUT_INV;
      dig_en_q   <= {DIGITS{OUT_INV}};
    end else begin
      seg_q    <= seg_d ^ {7{OUT_INV}};
      dp_q     <= dp_d ^ OUT_INV;
      dig_en_q <= dig_en_d ^ {DIGITS{OUT_INV}};

      if (commit) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
        ready_q    <= 1'b1;
      end else if (transfer) begin
        pend_val_q <= load_if.load_value;
        pend_dp_q  <= load_if.load_dp;
        ready_q    <= 1'b0;
      end

      case (state_q)
        ST_GAP: begin
          if (gap_done) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (show_done) begin
            cnt_q <= '0;
            idx_q <= idx_nxt;
            if (GAP_CYCLES != 0) state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_GAP;
      endcase
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign dig_en = dig_en_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with DIGITS=2, REFRESH_DIV=4,
// GAP_CYCLES=1, ACTIVE_LOW=1 (one frame = 10 cycles). Outputs are sampled
// 1 time unit after each rising edge. Leading-zero expectations follow
// SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_segment_scan;
  localparam int DIGITS = 2;

  logic       clk = 1'b0;
  logic       rst, hex_mode, blank;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig_en;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  seven_segment_scan_if #(.DIGITS(DIGITS)) load_if ();

  seven_segment_scan #(
    .DIGITS(DIGITS), .REFRESH_DIV(4), .GAP_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load_if(load_if), .hex_mode(hex_mode),
    .blank(blank), .seg(seg), .dp(dp), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until the given digit shows the given segments.
  task automatic wait_lit(input logic [1:0] en, input logic [6:0] sg, input int limit,
                          output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      tick();
      cycles++;
      if (dig_en === en && seg === sg) ok = 1'b1;
    end
  endtask

  // Offers a value, waits (bounded) for ready, completes the transfer edge.
  task automatic offer(input logic [7:0] v, input logic [1:0] d, output bit ok);
    int n = 0;
    load_if.load_valid = 1'b1;
    load_if.load_value = v;
    load_if.load_dp    = d;
    while (load_if.load_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    ok = (load_if.load_ready === 1'b1);
    tick();
    load_if.load_valid = 1'b0;
    $display("load value=%h dp=%b accepted=%0d", v, d, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1; hex_mode = 1'b1; blank = 1'b0;
    load_if.load_valid = 1'b0; load_if.load_value = '0; load_if.load_dp = '0;
    tick(); tick();
    total_cnt++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else pass_cnt++;
    total_cnt++; if (dig_en !== 2'b11) $display("FAIL reset_dig_en: got %b want 11", dig_en); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", load_if.load_ready); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (dig_en !== 2'b11) $display("FAIL release_gap: got %b want 11", dig_en); else pass_cnt++;
    tick();
    total_cnt++; if (dig_en !== 2'b10) $display("FAIL first_lit_en: got %b want 10", dig_en); else pass_cnt++;
    total_cnt++; if (seg !== 7'h40) $display("FAIL first_lit_seg: got %h want 40", seg); else pass_cnt++;
  endtask

  task automatic test_hex_load();
    bit ok; int cyc;
    logic [1:0] en_exp; logic [6:0] seg_exp; logic dp_exp;
    hex_mode = 1'b1;
    offer(8'h42, 2'b10, ok);
    total_cnt++; if (!ok) $display("FAIL hex_offer: got timeout want ready"); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b0) $display("FAIL hex_ready_low: got %b want 0", load_if.load_ready); else pass_cnt++;
    wait_lit(2'b10, 7'h24, 30, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL hex_visible: got timeout want dig_en 10 seg 24"); else pass_cnt++;
    total_cnt++; if (cyc > 11) $display("FAIL hex_latency: got %0d want <=11", cyc); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL hex_ready_back: got %b want 1", load_if.load_ready); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL hex_dp0: got %b want 1", dp); else pass_cnt++;
    for (int k = 1; k < 20; k++) begin
      tick();
      case (k % 10)
        0, 1, 2, 3:  begin en_exp = 2'b10; seg_exp = 7'h24; dp_exp = 1'b1; end
        5, 6, 7, 8:  begin en_exp = 2'b01; seg_exp = 7'h19; dp_exp = 1'b0; end
        default:     begin en_exp = 2'b11; seg_exp = 7'h7F; dp_exp = 1'b1; end
      endcase
      total_cnt++; if (dig_en !== en_exp) $display("FAIL hex_scan_en[%0d]: got %b want %b", k, dig_en, en_exp); else pass_cnt++;
      total_cnt++; if (seg !== seg_exp) $display("FAIL hex_scan_seg[%0d]: got %h want %h", k, seg, seg_exp); else pass_cnt++;
      total_cnt++; if (dp !== dp_exp) $display("FAIL hex_scan_dp[%0d]: got %b want %b", k, dp, dp_exp); else pass_cnt++;
    end
  endtask

  task automatic test_mode();
    bit ok; int cyc;
    hex_mode = 1'b0;
    offer(8'h0C, 2'b00, ok);
    total_cnt++; if (!ok) $display("FAIL mode_offer: got timeout want ready"); else pass_cnt++;
    wait_lit(2'b10, 7'h3F, 30, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL mode_dash: got timeout want seg 3f"); else pass_cnt++;
    hex_mode = 1'b1;
    tick();
    total_cnt++; if (dig_en !== 2'b10) $display("FAIL mode_live_en: got %b want 10", dig_en); else pass_cnt++;
    total_cnt++; if (seg !== 7'h46) $display("FAIL mode_live_seg: got %h want 46", seg); else pass_cnt++;
    wait_lit(2'b01, 7'h40, 10, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL mode_digit1: got timeout want seg 40"); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc;
    logic [6:0] seg_exp;
    hex_mode = 1'b1;
    offer(8'h11, 2'b00, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_offer: got timeout want ready"); else pass_cnt++;
    load_if.load_valid = 1'b1;
    load_if.load_value = 8'h22;
    total_cnt++; if (load_if.load_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", load_if.load_ready); else pass_cnt++;
    wait_lit(2'b10, 7'h79, 30, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_first: got timeout want seg 79"); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b0) $display("FAIL b2b_second_taken: got %b want 0", load_if.load_ready); else pass_cnt++;
    load_if.load_valid = 1'b0;
    $display("load value=22 dp=00 accepted=1");
    for (int k = 1; k < 20; k++) begin
      tick();
      seg_exp = (k < 10) ? 7'h79 : 7'h24;
      if (dig_en !== 2'b11) begin
        total_cnt++; if (seg !== seg_exp) $display("FAIL b2b_frame[%0d]: got %h want %h", k, seg, seg_exp); else pass_cnt++;
      end
    end
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL b2b_ready_end: got %b want 1", load_if.load_ready); else pass_cnt++;
  endtask

  task automatic test_blank();
    bit ok; int cyc;
    logic [1:0] exp_seq [4] = '{2'b01, 2'b01, 2'b11, 2'b10};
    wait_lit(2'b01, 7'h24, 20, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL blank_sync: got timeout want digit1"); else pass_cnt++;
    blank = 1'b1;
    tick();
    total_cnt++; if (dig_en !== 2'b11) $display("FAIL blank_off: got %b want 11", dig_en); else pass_cnt++;
    blank = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++; if (dig_en !== exp_seq[k]) $display("FAIL blank_resume[%0d]: got %b want %b", k, dig_en, exp_seq[k]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_pending();
    bit ok; int lit;
    offer(8'h37, 2'b00, ok);
    total_cnt++; if (!ok) $display("FAIL rstp_offer: got timeout want ready"); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b0) $display("FAIL rstp_pending: got %b want 0", load_if.load_ready); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL rstp_ready: got %b want 1", load_if.load_ready); else pass_cnt++;
    total_cnt++; if (dig_en !== 2'b11) $display("FAIL rstp_dig_en: got %b want 11", dig_en); else pass_cnt++;
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dig_en !== 2'b11) begin
        lit++;
        total_cnt++; if (seg !== 7'h40) $display("FAIL rstp_zero[%0d]: got %h want 40", k, seg); else pass_cnt++;
      end
    end
    total_cnt++; if (lit != 16) $display("FAIL rstp_lit_count: got %0d want 16", lit); else pass_cnt++;
  endtask

  task automatic test_leading_zero();
    bit ok; int cyc;
    logic [6:0] d1_exp;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    d1_exp = 7'h7F;
`else
    d1_exp = 7'h40;
`endif
    hex_mode = 1'b0;
    offer(8'h05, 2'b00, ok);
    total_cnt++; if (!ok) $display("FAIL lz_offer: got timeout want ready"); else pass_cnt++;
    wait_lit(2'b10, 7'h12, 30, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL lz_digit0: got timeout want seg 12"); else pass_cnt++;
    wait_lit(2'b01, d1_exp, 10, cyc, ok);
    total_cnt++; if (!ok) $display("FAIL lz_digit1: got seg %h want %h", seg, d1_exp); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL lz_dp: got %b want 1", dp); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_hex_load();
    test_mode();
    test_back_to_back();
    test_blank();
    test_reset_pending();
    test_leading_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
